router_pkt_tx: RTL and testbench

Packet transmitter that drives the router's input port; it is the sending end of the router packet protocol. It accepts a destination and length request, buffers the whole payload from a byte stream, then emits a header byte, the payload bytes and an even-parity byte on `data_out`/`pkt_valid`. It obeys the router's `busy` back-pressure. It sits in front of the router top in host-side and testbench-side integration.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_pkt_tx_if.sv | 30 +++
 rtl/router_tx_buf.sv | 22 ++
 rtl/router_pkt_tx.sv | 165 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states and header layout.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PAY,
    PAR,
    GAP
  } tx_state_e;

  localparam int         ADDR_LSB     = 0;
  localparam int         LEN_LSB      = 2;
  localparam logic [1:0] DEST_INVALID = 2'b11;

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet transmitter.
// The master modport is the transmitter; the slave modport is the host/router side.
interface router_pkt_tx_if #(
  parameter int LEN_W = 6
);

  logic             req_valid;
  logic [1:0]       req_dest;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             pay_valid;
  logic [7:0]       pay_data;
  logic             pay_ready;
  logic             busy;
  logic             pkt_valid;
  logic [7:0]       data_out;
  logic             tx_done;
  logic             req_err;

  modport master (
    input  req_valid, req_dest, req_len, pay_valid, pay_data, busy,
    output req_ready, pay_ready, pkt_valid, data_out, tx_done, req_err
  );

  modport slave (
    output req_valid, req_dest, req_len, pay_valid, pay_data, busy,
    input  req_ready, pay_ready, pkt_valid, data_out, tx_done, req_err
  );

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer: 2^AW x 8 register array, synchronous write, combinational read.
module router_tx_buf #(
  parameter int AW = 6
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];

  // NOTE: the array is deliberately not reset; every location read in a packet was written earlier in that packet.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends header, payload and parity.
// Optional macro ROUTER_TX_ERR_INJ_EN adds inj_err to invert the parity of a requested packet. IDLE_GAP must be >= 1.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int LEN_W    = 6,
  parameter int IDLE_GAP = 2
) (
  input  logic clock,
  input  logic resetn,
`ifdef ROUTER_TX_ERR_INJ_EN
  input  logic inj_err,
`endif
  router_pkt_tx_if.master bus
);

  localparam int GAP_W = (IDLE_GAP > 2) ? $clog2(IDLE_GAP) : 1;

  tx_state_e        r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [7:0]       r_hdr;
  logic [7:0]       r_par, w_par_nxt;
  logic             r_pkt_valid, w_pkt_valid_nxt;
  logic [7:0]       r_data_out, w_data_nxt;
  logic             r_tx_done, w_tx_done_nxt;
  logic             r_req_err, w_req_err_nxt;
  logic             w_latch_req;
  logic             w_req_bad;
  logic [7:0]       w_hdr_in;
  logic [7:0]       w_par_out;
  logic [7:0]       w_rdata;
  logic             w_buf_we;

  assign w_hdr_in  = (8'(bus.req_len) << LEN_LSB) | (8'(bus.req_dest) << ADDR_LSB);
  assign w_req_bad = (bus.req_dest == DEST_INVALID) || (bus.req_len == '0);
  assign w_buf_we  = (r_state == LOAD) && bus.pay_valid;

`ifdef ROUTER_TX_ERR_INJ_EN
  logic r_inj;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          r_inj <= 1'b0;
    else if (w_latch_req) r_inj <= inj_err;
  end

  assign w_par_out = r_par ^ {8{r_inj}};
`else
  assign w_par_out = r_par;
`endif

  // r_cnt is the write address while loading and the next-byte read address while sending.
  router_tx_buf #(.AW(LEN_W)) u_buf (
    .clock   (clock),
    .i_we    (w_buf_we),
    .i_waddr (r_cnt),
    .i_wdata (bus.pay_data),
    .i_raddr (r_cnt),
    .o_rdata (w_rdata)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every signal gets its hold/idle value first, so no path through the case can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gap_nxt       = r_gap;
    w_par_nxt       = r_par;
    w_pkt_valid_nxt = r_pkt_valid;
    w_data_nxt      = r_data_out;
    w_tx_done_nxt   = 1'b0;
    w_req_err_nxt   = 1'b0;
    w_latch_req     = 1'b0;
    case (r_state)
      IDLE: if (bus.req_valid) begin
        if (w_req_bad) begin
          w_req_err_nxt = 1'b1;
        end else begin
          w_latch_req = 1'b1;
          w_cnt_nxt   = '0;
          w_par_nxt   = w_hdr_in;
          w_state_nxt = LOAD;
        end
      end
      LOAD: if (bus.pay_valid) begin
        w_par_nxt = r_par ^ bus.pay_data;
        if (r_cnt == r_len - 1'b1) begin
          w_cnt_nxt       = '0;
          w_pkt_valid_nxt = 1'b1;
          w_data_nxt      = r_hdr;
          w_state_nxt     = HDR;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HDR: if (!bus.busy) begin
        w_data_nxt  = w_rdata;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_state_nxt = PAY;
      end
      // r_cnt == r_len means the byte on data_out is the last one.
      PAY: if (!bus.busy) begin
        if (r_cnt == r_len) begin
          w_pkt_valid_nxt = 1'b0;
          w_data_nxt      = w_par_out;
          w_state_nxt     = PAR;
        end else begin
          w_data_nxt = w_rdata;
          w_cnt_nxt  = r_cnt + 1'b1;
        end
      end
      PAR: if (!bus.busy) begin
        w_tx_done_nxt = 1'b1;
        w_data_nxt    = 8'h00;
        w_gap_nxt     = '0;
        w_state_nxt   = GAP;
      end
      GAP: begin
        if (r_gap == GAP_W'(IDLE_GAP - 1)) w_state_nxt = IDLE;
        else                               w_gap_nxt   = r_gap + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_len       <= '0;
      r_hdr       <= 8'h00;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_par       <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_data_out  <= 8'h00;
      r_tx_done   <= 1'b0;
      r_req_err   <= 1'b0;
    end else begin
      if (w_latch_req) begin
        r_len <= bus.req_len;
        r_hdr <= w_hdr_in;
      end
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_par       <= w_par_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_data_out  <= w_data_nxt;
      r_tx_done   <= w_tx_done_nxt;
      r_req_err   <= w_req_err_nxt;
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.pay_ready = (r_state == LOAD);
  assign bus.pkt_valid = r_pkt_valid;
  assign bus.data_out  = r_data_out;
  assign bus.tx_done   = r_tx_done;
  assign bus.req_err   = r_req_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: table of packet requests plus reset and parity-injection sequences.
module tb_router_pkt_tx;

  localparam int LEN_W = 6;

  logic clock = 1'b0;
  logic resetn;
`ifdef ROUTER_TX_ERR_INJ_EN
  logic inj_err;
`endif

  router_pkt_tx_if #(.LEN_W(LEN_W)) ifc ();

  router_pkt_tx #(.LEN_W(LEN_W), .IDLE_GAP(2)) dut (
    .clock   (clock),
    .resetn  (resetn),
`ifdef ROUTER_TX_ERR_INJ_EN
    .inj_err (inj_err),
`endif
    .bus     (ifc.master)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard: header, payload and parity bytes pushed by the driver, popped when consumed.
  logic [7:0] exp_q[$];
  int         hold_q[$];
  int         hold;
  bit         mon_en;
  bit         in_pkt;
  bit         done_pend;
  int         pv_cnt;
  logic [7:0] last_par;

  initial begin
    logic [7:0] e;
    mon_en = 0; in_pkt = 0; done_pend = 0; hold = 0; pv_cnt = 0; last_par = 8'h00;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (done_pend || ifc.tx_done) check("tx_done", 32'(ifc.tx_done), 32'(done_pend));
        done_pend = 0;
        if (ifc.pkt_valid) pv_cnt++;
        if (ifc.pkt_valid || in_pkt) begin
          hold++;
          if (!ifc.busy) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              if (ifc.pkt_valid) begin
                check("tx_byte", 32'(ifc.data_out), 32'(e));
              end else begin
                check("tx_parity", 32'(ifc.data_out), 32'(e));
                last_par  = ifc.data_out;
                done_pend = 1;
              end
              hold_q.push_back(hold);
              hold   = 0;
              in_pkt = ifc.pkt_valid;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic [1:0] dest;
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    bit         toggle;
    int         busy_idx;  // payload index held by busy; -1 = header, len = parity
    int         busy_n;
    bit         exp_err;
    int         exp_par;   // -1 = checked against the scoreboard model only
  } vec_t;

  task automatic send_pkt(input logic [1:0] dest, input int len, input logic [7:0] base,
                          input logic [7:0] step, input bit toggle, input int busy_idx,
                          input int busy_n, input bit exp_err, input bit inj, input int abort_at);
    logic [7:0] hdr, par, b;
    int waited, k, tx_cyc, busy_left, pv0;
    waited = 0;
    while (!ifc.req_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    check("req_ready", 32'(ifc.req_ready), 32'd1);
    hdr = {6'(len), dest};
    ifc.req_valid = 1'b1;
    ifc.req_dest  = dest;
    ifc.req_len   = LEN_W'(len);
`ifdef ROUTER_TX_ERR_INJ_EN
    inj_err = inj;
`endif
    if (exp_err) begin
      @(posedge clock); #1;
      ifc.req_valid = 1'b0;
      check("req_err_pulse", 32'(ifc.req_err), 32'd1);
      check("req_ready_after_err", 32'(ifc.req_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
        @(posedge clock); #1;
        check("req_err_one_cycle", 32'(ifc.req_err), 32'd0);
        check("no_pkt_valid_after_err", 32'(ifc.pkt_valid), 32'd0);
      end
      return;
    end
    par = hdr;
    hold_q.delete();
    hold = 0;
    exp_q.push_back(hdr);
    @(posedge clock); #1;
    ifc.req_valid = 1'b0;
    check("req_err_quiet", 32'(ifc.req_err), 32'd0);
    for (int i = 0; i < len; i++) begin
      if (toggle) begin
        ifc.pay_valid = 1'b0;
        check("pay_ready_idle_cycle", 32'(ifc.pay_ready), 32'd1);
        @(posedge clock); #1;
      end
      b = 8'(base + step * 8'(i));
      ifc.pay_valid = 1'b1;
      ifc.pay_data  = b;
      check("pay_ready", 32'(ifc.pay_ready), 32'd1);
      check("no_pkt_valid_in_load", 32'(ifc.pkt_valid), 32'd0);
      par = par ^ b;
      exp_q.push_back(b);
      @(posedge clock); #1;
    end
    ifc.pay_valid = 1'b0;
    check("pay_ready_drop", 32'(ifc.pay_ready), 32'd0);
    check("hdr_valid_next_cycle", 32'(ifc.pkt_valid), 32'd1);
    check("hdr_byte_next_cycle", 32'(ifc.data_out), 32'(hdr));
`ifdef ROUTER_TX_ERR_INJ_EN
    if (inj) par = ~par;
`endif
    exp_q.push_back(par);
    pv0 = pv_cnt;
    k = 0; tx_cyc = 0; busy_left = busy_n;
    while (k < len + 2 && tx_cyc < 400) begin
      if (abort_at >= 0 && tx_cyc == abort_at) return;
      ifc.busy = (k == busy_idx + 1) && (busy_left > 0);
      if (ifc.busy) busy_left--;
      @(posedge clock); #1;
      if (!ifc.busy) k++;
      tx_cyc++;
    end
    ifc.busy = 1'b0;
    check("gap_pkt_valid", 32'(ifc.pkt_valid), 32'd0);
    check("gap_data_out", 32'(ifc.data_out), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("pkt_valid_cycles", 32'(pv_cnt - pv0), 32'(len + 1 + ((busy_idx < len) ? busy_n : 0)));
    check("items_consumed", 32'(hold_q.size()), 32'(len + 2));
    if (busy_n > 0 && hold_q.size() > busy_idx + 1)
      check("busy_hold_cycles", 32'(hold_q[busy_idx + 1]), 32'(busy_n + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{2'd1, 3,  8'h11, 8'h11, 1'b0,  0, 0, 1'b0, 'h0D};
    vt[1] = '{2'd1, 3,  8'h11, 8'h11, 1'b0,  1, 2, 1'b0, 'h0D};
    vt[2] = '{2'd3, 3,  8'h11, 8'h11, 1'b0,  0, 0, 1'b1, -1};
    vt[3] = '{2'd0, 0,  8'h11, 8'h11, 1'b0,  0, 0, 1'b1, -1};
    vt[4] = '{2'd2, 63, 8'h05, 8'h07, 1'b1,  0, 0, 1'b0, -1};
    vt[5] = '{2'd0, 2,  8'hA5, 8'h5A, 1'b0, -1, 3, 1'b0, 'h52};
    vt[6] = '{2'd2, 4,  8'h80, 8'h01, 1'b0,  4, 1, 1'b0, 'h12};

    resetn        = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_dest  = 2'd0;
    ifc.req_len   = '0;
    ifc.pay_valid = 1'b0;
    ifc.pay_data  = 8'h00;
    ifc.busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check("rst_pkt_valid", 32'(ifc.pkt_valid), 32'd0);
    check("rst_data_out", 32'(ifc.data_out), 32'd0);
    check("rst_tx_done", 32'(ifc.tx_done), 32'd0);
    check("rst_req_err", 32'(ifc.req_err), 32'd0);
    check("rst_pay_ready", 32'(ifc.pay_ready), 32'd0);
    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    resetn = 1'b1;
    mon_en = 1;

    for (int i = 0; i < 7; i++) begin
      send_pkt(vt[i].dest, vt[i].len, vt[i].base, vt[i].step, vt[i].toggle,
               vt[i].busy_idx, vt[i].busy_n, vt[i].exp_err, 1'b0, -1);
      if (!vt[i].exp_err && vt[i].exp_par >= 0)
        check("parity_value", 32'(last_par), 32'(vt[i].exp_par));
    end

    // Reset while a payload byte is on the bus, then a clean packet.
    send_pkt(2'd1, 3, 8'h11, 8'h11, 1'b0, 0, 0, 1'b0, 1'b0, 2);
    check("pre_reset_in_pay", 32'(ifc.pkt_valid), 32'd1);
    mon_en = 0;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_pkt_valid", 32'(ifc.pkt_valid), 32'd0);
    check("mid_rst_data_out", 32'(ifc.data_out), 32'd0);
    check("mid_rst_req_ready", 32'(ifc.req_ready), 32'd1);
    exp_q.delete();
    hold_q.delete();
    in_pkt = 0; done_pend = 0; hold = 0;
    @(posedge clock); #1;
    resetn = 1'b1;
    mon_en = 1;
    check("post_rst_req_ready", 32'(ifc.req_ready), 32'd1);
    send_pkt(2'd1, 3, 8'h11, 8'h11, 1'b0, 0, 0, 1'b0, 1'b0, -1);
    check("post_rst_parity", 32'(last_par), 32'h0D);

`ifdef ROUTER_TX_ERR_INJ_EN
    send_pkt(2'd1, 3, 8'h11, 8'h11, 1'b0, 0, 0, 1'b0, 1'b1, -1);
    check("inj_parity", 32'(last_par), 32'hF2);
    send_pkt(2'd1, 3, 8'h11, 8'h11, 1'b0, 0, 0, 1'b0, 1'b0, -1);
    check("after_inj_parity", 32'(last_par), 32'h0D);
`endif

    repeat (4) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
